// File: rtl/fp_mem_adder_pkg.sv
// Shared constants and FSM state encoding for the memory-to-memory
// single-precision adder.
package fp_mem_adder_pkg;

  localparam int EXP_W   = 8;
  localparam int MANT_W  = 23;
  localparam int EXP_MAX = 255;

  localparam logic [31:0] FP_INF = 32'h7F80_0000;

  typedef enum logic [3:0] {
    IDLE,
    RD_A,
    RD_B,
    CAP_B,
    ALIGN,
    ADD,
    NORM,
    WRITE,
    DONE
  } state_t;

endpackage

// File: rtl/fp_mem_adder_if.sv
// Request/status handshake plus the single-port RAM bus of the adder.
interface fp_mem_adder_if #(
  parameter int ADDR_W = 5
);

  logic              start;
  logic              op;
  logic [ADDR_W-1:0] src_a;
  logic [ADDR_W-1:0] src_b;
  logic [ADDR_W-1:0] dst;
  logic              busy;
  logic              done;
  logic              ovf;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (
    output start, op, src_a, src_b, dst, mem_rdata,
    input  busy, done, ovf, mem_addr, mem_we, mem_wdata
  );

  modport slave (
    input  start, op, src_a, src_b, dst, mem_rdata,
    output busy, done, ovf, mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/fp_align_add.sv
// Two-stage exponent compare / alignment / magnitude add-subtract datapath.
// Stage registers load on align_en and add_en respectively.
module fp_align_add
  import fp_mem_adder_pkg::*;
(
  input  logic             clk,
  input  logic             align_en,
  input  logic             add_en,
  input  logic [31:0]      a,
  input  logic [31:0]      b,
  input  logic             op,
  output logic [24:0]      sum,
  output logic [EXP_W-1:0] sum_exp,
  output logic             sum_sign,
  output logic             sum_inf
);

  logic [EXP_W-1:0] exp_a, exp_b, diff;
  logic [23:0]      mant_a, mant_b, small_mant, small_sh, big_mant;
  logic             b_larger_exp;

  logic [23:0]      ma_r, mb_r;
  logic [EXP_W-1:0] exp_r;
  logic             sa_r, sb_r, inf_r;

  logic [24:0]      sum_d;
  logic             sign_d;

  // Exponent-0 inputs become true zero so they never lead the alignment.
  always_comb begin
    exp_a        = a[30:23];
    exp_b        = b[30:23];
    mant_a       = (exp_a == '0) ? 24'd0 : {1'b1, a[22:0]};
    mant_b       = (exp_b == '0) ? 24'd0 : {1'b1, b[22:0]};
    b_larger_exp = exp_b > exp_a;
    diff         = b_larger_exp ? (exp_b - exp_a) : (exp_a - exp_b);
    small_mant   = b_larger_exp ? mant_a : mant_b;
    big_mant     = b_larger_exp ? mant_b : mant_a;
    small_sh     = (diff >= 8'd24) ? 24'd0 : (small_mant >> diff);
  end

  always_ff @(posedge clk) begin
    if (align_en) begin
      ma_r  <= b_larger_exp ? small_sh : big_mant;
      mb_r  <= b_larger_exp ? big_mant : small_sh;
      exp_r <= b_larger_exp ? exp_b : exp_a;
      sa_r  <= a[31];
      sb_r  <= b[31] ^ op;
      inf_r <= (exp_a == 8'(EXP_MAX)) || (exp_b == 8'(EXP_MAX));
    end
  end

  // Unlike signs subtract the smaller magnitude; the larger one sets the sign.
  always_comb begin
    sum_d  = {1'b0, ma_r} + {1'b0, mb_r};
    sign_d = sa_r;
    if (sa_r ^ sb_r) begin
      if (ma_r >= mb_r) begin
        sum_d  = {1'b0, ma_r - mb_r};
        sign_d = sa_r;
      end else begin
        sum_d  = {1'b0, mb_r - ma_r};
        sign_d = sb_r;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (add_en) begin
      sum      <= sum_d;
      sum_exp  <= exp_r;
      sum_sign <= sign_d;
      sum_inf  <= inf_r;
    end
  end

endmodule

// File: rtl/fp_mem_adder.sv
// Sequencer that reads two floats from RAM, adds or subtracts them with
// truncation, normalises iteratively and writes the result back.
module fp_mem_adder
  import fp_mem_adder_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int NORM_MAX = 24
) (
  input  logic           clk,
  input  logic           rst,
  fp_mem_adder_if.slave  bus
);

  state_t state, state_next;

  logic              op_r;
  logic [ADDR_W-1:0] src_a_r, src_b_r, dst_r;
  logic [31:0]       a_r, b_r, res_r;
  logic              ovf_r, first_norm;
  logic [23:0]       mant_r, cur_mant;
  logic [8:0]        exp_r, cur_exp;
  logic [7:0]        norm_cnt;

  logic [24:0]       sum;
  logic [EXP_W-1:0]  sum_exp;
  logic              sum_sign, sum_inf;

  logic              norm_exit, norm_ovf;
  logic [31:0]       norm_res;

  fp_align_add u_align_add (
    .clk      (clk),
    .align_en (state == ALIGN),
    .add_en   (state == ADD),
    .a        (a_r),
    .b        (b_r),
    .op       (op_r),
    .sum      (sum),
    .sum_exp  (sum_exp),
    .sum_sign (sum_sign),
    .sum_inf  (sum_inf)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // The first NORM cycle folds in the carry-out right shift.
  always_comb begin
    cur_mant = mant_r;
    cur_exp  = exp_r;
    if (first_norm) begin
      cur_mant = sum[24] ? sum[24:1] : sum[23:0];
      cur_exp  = {1'b0, sum_exp} + {8'd0, sum[24]};
    end
  end

  always_comb begin
    norm_exit = 1'b1;
    norm_ovf  = 1'b0;
    norm_res  = 32'h0;
    if (sum_inf) begin
      norm_res = FP_INF;
      norm_ovf = 1'b1;
    end else if (cur_mant == 24'd0) begin
      norm_res = 32'h0;
    end else if (cur_exp >= 9'(EXP_MAX)) begin
      norm_res = {sum_sign, FP_INF[30:0]};
      norm_ovf = 1'b1;
    end else if (cur_exp == 9'd0) begin
      norm_res = 32'h0;
    end else if (cur_mant[23]) begin
      norm_res = {sum_sign, cur_exp[7:0], cur_mant[22:0]};
    end else if (norm_cnt != 8'(NORM_MAX)) begin
      norm_exit = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_r <= 1'b0; src_a_r <= '0; src_b_r <= '0; dst_r <= '0;
      a_r <= '0; b_r <= '0; res_r <= '0; ovf_r <= 1'b0;
      first_norm <= 1'b0; mant_r <= '0; exp_r <= '0; norm_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          op_r    <= bus.op;
          src_a_r <= bus.src_a;
          src_b_r <= bus.src_b;
          dst_r   <= bus.dst;
        end
        RD_B:  a_r <= bus.mem_rdata;
        CAP_B: b_r <= bus.mem_rdata;
        ADD: begin
          first_norm <= 1'b1;
          norm_cnt   <= '0;
        end
        NORM: begin
          first_norm <= 1'b0;
          if (norm_exit) begin
            res_r <= norm_res;
            ovf_r <= norm_ovf;
          end else begin
            mant_r   <= cur_mant << 1;
            exp_r    <= cur_exp - 9'd1;
            norm_cnt <= norm_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next    = state;
    bus.busy      = (state != IDLE);
    bus.done      = (state == DONE);
    bus.ovf       = (state == DONE) && ovf_r;
    bus.mem_we    = (state == WRITE);
    bus.mem_wdata = (state == WRITE) ? res_r : 32'h0;
    bus.mem_addr  = '0;
    case (state)
      IDLE:    if (bus.start) state_next = RD_A;
      RD_A: begin
        bus.mem_addr = src_a_r;
        state_next   = RD_B;
      end
      RD_B: begin
        bus.mem_addr = src_b_r;
        state_next   = CAP_B;
      end
      CAP_B:   state_next = ALIGN;
      ALIGN:   state_next = ADD;
      ADD:     state_next = NORM;
      NORM:    if (norm_exit) state_next = WRITE;
      WRITE: begin
        bus.mem_addr = dst_r;
        state_next   = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fp_mem_adder.sv
// Vector table plus scoreboard for fp_mem_adder, with reset-abort and
// ignored-start corner sequences.
module tb_fp_mem_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_mem_adder_if #(.ADDR_W(5)) bus();

  fp_mem_adder #(.ADDR_W(5), .NORM_MAX(24)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    int          n;
    logic [31:0] res;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [4:0]  dst;
    logic [31:0] res;
    logic        ovf;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  vec_t        vecs[14];
  logic [31:0] mem[32];
  logic        load_en;
  logic [4:0]  load_addr;
  logic [31:0] load_data;
  int          cyc = 0;
  int          start_cyc = 0;
  int          tests = 0;
  int          fails = 0;
  int          wr_count = 0;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  bit          done_seen;

  // Synchronous-read RAM with a backdoor load port for the bench.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (load_en) mem[load_addr] <= load_data;
    else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every done pulse retires one expected result.
  always @(negedge clk) begin
    if (bus.mem_we) begin
      wr_count = wr_count + 1;
      wr_addr  = bus.mem_addr;
      wr_data  = bus.mem_wdata;
    end
    if (bus.done) begin
      done_seen = 1'b1;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_done: got done=1, expected no done");
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("wr_addr", 32'(wr_addr), 32'(mon_e.dst));
        checkOutput("wr_data", wr_data, mon_e.res);
        checkOutput("mem_dst", mem[mon_e.dst], mon_e.res);
        checkOutput("ovf", 32'(bus.ovf), 32'(mon_e.ovf));
        checkOutput("latency", 32'(cyc - start_cyc), 32'(mon_e.lat));
        checkOutput("wr_count", 32'(wr_count), 32'd1);
      end
    end
  end

  task automatic loadWord(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    load_en = 1'b1; load_addr = addr; load_data = data;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, input logic [4:0] sa, input logic [4:0] sb,
                               input logic [4:0] d, input bit pulse_mid);
    exp_t e;
    loadWord(sa, v.a);
    loadWord(sb, v.b);
    e.dst = d; e.res = v.res; e.ovf = v.ovf; e.lat = 7 + v.n;
    exp_q.push_back(e);
    done_seen = 1'b0;
    wr_count  = 0;
    bus.start = 1'b1; bus.op = v.op; bus.src_a = sa; bus.src_b = sb; bus.dst = d;
    start_cyc = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("busy_run", 32'(bus.busy), 32'd1);
    if (pulse_mid) begin
      @(negedge clk);
      bus.start = 1'b1; bus.dst = d + 5'd1; bus.op = ~v.op;
      @(negedge clk);
      bus.start = 1'b0;
    end
    for (int t = 0; t < 80 && !done_seen; t++) begin
      @(negedge clk);
      #1;
    end
    if (!done_seen) begin
      tests++;
      fails++;
      $display("[TB] FAIL done_timeout: got no done, expected done within 80 cycles");
      exp_q.delete();
    end
    @(negedge clk);
    checkOutput("busy_after", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{32'h41D00000, 32'h42700000, 1'b0, 1,  32'h42AC0000, 1'b0};
    vecs[1]  = '{32'h3FC00000, 32'h3FA00000, 1'b1, 3,  32'h3E800000, 1'b0};
    vecs[2]  = '{32'h40A00000, 32'h40A00000, 1'b1, 1,  32'h00000000, 1'b0};
    vecs[3]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 1,  32'h7F800000, 1'b1};
    vecs[4]  = '{32'h41D00000, 32'h42700000, 1'b1, 1,  32'hC2080000, 1'b0};
    vecs[5]  = '{32'h3F800000, 32'h3F800000, 1'b0, 1,  32'h40000000, 1'b0};
    vecs[6]  = '{32'h7F800000, 32'h3F800000, 1'b0, 1,  32'h7F800000, 1'b1};
    vecs[7]  = '{32'h00000001, 32'h3F800000, 1'b0, 1,  32'h3F800000, 1'b0};
    vecs[8]  = '{32'h4B800000, 32'h3F800000, 1'b0, 1,  32'h4B800000, 1'b0};
    vecs[9]  = '{32'h4B000000, 32'h3F800000, 1'b0, 1,  32'h4B000001, 1'b0};
    vecs[10] = '{32'hC0000000, 32'hBF800000, 1'b0, 1,  32'hC0400000, 1'b0};
    vecs[11] = '{32'h3F800000, 32'hBF800000, 1'b1, 1,  32'h40000000, 1'b0};
    vecs[12] = '{32'h00800000, 32'h00C00000, 1'b1, 2,  32'h00000000, 1'b0};
    vecs[13] = '{32'h3F800000, 32'h3F7FFFFF, 1'b1, 24, 32'h34000000, 1'b0};

    load_en = 1'b0; load_addr = '0; load_data = '0;
    bus.start = 1'b0; bus.op = 1'b0; bus.src_a = '0; bus.src_b = '0; bus.dst = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    checkOutput("rst_ovf", 32'(bus.ovf), 32'd0);
    checkOutput("rst_we", 32'(bus.mem_we), 32'd0);
    checkOutput("rst_addr", 32'(bus.mem_addr), 32'd0);
    checkOutput("rst_wdata", bus.mem_wdata, 32'd0);
    rst = 1'b0;

    applyStimulus(vecs[0], 5'd0, 5'd1, 5'd2, 1'b0);
    for (int i = 1; i < 14; i++) begin
      applyStimulus(vecs[i], 5'd1, 5'd2, (i % 4 == 3) ? 5'd1 : 5'(3 + i), (i % 5 == 2));
    end

    // Reset in the middle of normalisation must abort without a write.
    loadWord(5'd1, 32'h3FC00000);
    loadWord(5'd2, 32'h3FA00000);
    loadWord(5'd3, 32'hDEADBEEF);
    wr_count  = 0;
    bus.start = 1'b1; bus.op = 1'b1; bus.src_a = 5'd1; bus.src_b = 5'd2; bus.dst = 5'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("abort_busy_pre", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    repeat (12) @(negedge clk);
    checkOutput("abort_writes", 32'(wr_count), 32'd0);
    checkOutput("abort_mem", mem[3], 32'hDEADBEEF);
    applyStimulus(vecs[1], 5'd1, 5'd2, 5'd3, 1'b0);

    // Reset wins over a simultaneous start.
    rst = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.start = 1'b0;
    checkOutput("rst_prio_busy", 32'(bus.busy), 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("rst_prio_idle", 32'(bus.busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fp_mem_adder.md
FP_MEM_ADDER -- requirements
Module: fp_mem_adder

Interface
REQ-001 Parameter ADDR_W, default 5, word-address width of the attached 32x32 RAM.
REQ-002 Parameter NORM_MAX, default 24, maximum left-normalisation cycles before the result is forced to zero.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request pulse; sampled only in IDLE.
REQ-006 op  input  1  0 = mem[src_a] + mem[src_b], 1 = mem[src_a] - mem[src_b]; captured with start.
REQ-007 src_a, src_b, dst  input  ADDR_W  operand and result addresses; captured with start.
REQ-008 busy  output  1  high from the cycle after start is accepted through the DONE cycle inclusive.
REQ-009 done  output  1  one-cycle pulse after the result write.
REQ-010 ovf  output  1  valid with done; result saturated to infinity.
REQ-011 mem_addr  output  ADDR_W  RAM address.
REQ-012 mem_we  output  1  RAM write strobe.
REQ-013 mem_wdata  output  32  RAM write data.
REQ-014 mem_rdata  input  32  RAM read data, valid one cycle after mem_addr is presented with mem_we=0.

Function
REQ-015 The FSM SHALL use states IDLE, RD_A, RD_B, CAP_B, ALIGN, ADD, NORM, WRITE, DONE.
REQ-016 Transitions: IDLE->RD_A on start; RD_A, RD_B, CAP_B, ALIGN and ADD each last one cycle; NORM lasts n>=1 cycles; WRITE and DONE last one cycle; DONE->IDLE.
REQ-017 RD_A drives src_a; RD_B drives src_b and captures A from mem_rdata; CAP_B captures B.
REQ-018 The done pulse SHALL occur in cycle 7+n after the start-accept edge; n = 1 + left shifts performed.
REQ-019 ALIGN: operand with the smaller exponent shifted right by the exponent difference; difference >= 24 yields zero mantissa; ties keep A as reference.
REQ-020 Inputs with exponent 0 SHALL be treated as +0 (denormals flushed); exponent 255 inputs SHALL produce 0x7F800000 with ovf=1.
REQ-021 ADD: effective sign = sign_a XOR sign_b XOR op; magnitudes added (25-bit) or larger minus smaller; result sign = sign of the larger-magnitude operand (B sign inverted when op=1).
REQ-022 NORM: first cycle applies a 1-bit right shift and exponent+1 on carry-out; each further cycle shifts left 1 and decrements the exponent until bit 23 is set.
REQ-023 Zero magnitude, NORM_MAX reached, or exponent reaching 0 SHALL produce 0x00000000 (never -0).
REQ-024 Exponent reaching 255 SHALL produce sign|0x7F800000 with ovf=1.
REQ-025 Mantissa SHALL be truncated; no rounding, no guard bits.
REQ-026 WRITE: mem_addr=dst, mem_we=1, mem_wdata=result for exactly one cycle; mem_we=0 in all other states.
REQ-027 start while busy SHALL be ignored; dst equal to src_a/src_b is legal (reads complete before the write).

Reset
REQ-028 rst SHALL force IDLE; busy, done, ovf, mem_we = 0; mem_addr, mem_wdata = 0.
REQ-029 rst in any state, including mid-NORM or WRITE, SHALL abort with no subsequent write.
REQ-030 rst has priority over start in the same cycle.

Structure
REQ-031 A shared package SHALL hold EXP_W=8, MANT_W=23, EXP_MAX=255, the FSM state enum and the +INF constant 0x7F800000.
REQ-032 The exponent-compare/align/add datapath SHALL be a sub-module fp_align_add; the FSM and normalisation loop stay in fp_mem_adder.

Verification
REQ-033 Add: mem[0]=0x41D00000 (26.0), mem[1]=0x42700000 (60.0), start op=0 dst=2 -> mem[2]=0x42AC0000, done in cycle 8, ovf=0.
REQ-034 Subtract with normalisation: 0x3FC00000 (1.5) - 0x3FA00000 (1.25) -> 0x3E800000 (0.25), n=3, done in cycle 10.
REQ-035 Cancellation: 0x40A00000 - 0x40A00000 -> 0x00000000, never 0x80000000.
REQ-036 Overflow: 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, ovf=1 with done.
REQ-037 Negative result: 0x41D00000 (26) - 0x42700000 (60) -> 0xC2080000 (-34).
REQ-038 rst asserted during NORM -> busy=0 next cycle, dst unchanged, new start accepted normally.
